wb_master: RTL and testbench

- Wishbone initiator, the mirror of the site's Wishbone slave port.
- Turns single-beat commands into classic Wishbone read/write cycles, supervises each cycle with a timeout, and returns one response per command.
- Used by the io-pin command path and by block-level benches to drive a toysram site's config and array space.
- Strictly one outstanding transaction; no pipelining, no bursts.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_timeout_ctr.sv | 36 +++
 rtl/wb_master.sv | 142 ++++++++++++++
 tb/tb_wb_master.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the Wishbone initiator.
//   - bus widths (address, data, byte-select)
//   - default data word returned for a timed-out read
//   - FSM state encoding used by wb_master
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [WB_DAT_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: counts bus cycles spent waiting for ack.
// Ports:
//   clk      single clock
//   rst      synchronous active-high reset (count -> 0)
//   clr      restart the count at 0 (start of a bus cycle)
//   en       count this cycle (waiting, no ack)
//   expired  count has reached TIMEOUT_CYCLES-1
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Holds at the terminal value so the count can never wrap back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != TERM)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == TERM);

endmodule

// File: rtl/wb_master.sv
// wb_master: single-outstanding Wishbone classic initiator.
// Accepts one command at a time, runs one Wishbone cycle with a timeout
// and returns one response per command.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_val/cmd_rdy               command handshake (ready only in IDLE)
//   cmd_we/adr/sel/dat            command fields
//   rsp_val/rsp_rdy               response handshake
//   rsp_we/err/dat                response fields (err = timeout)
//   wbm_*                         Wishbone initiator bus
//   busy                          FSM not idle
//   txn_cnt                       completed transactions (wraps)
//   err_cnt                       timeouts (saturates at 255)
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | waiting for a command, cmd_rdy high
// BUS     | cyc/stb asserted, waiting for ack or timeout
// RSP     | response presented, waiting for rsp_rdy
module wb_master
  import wb_pkg::*;
#(
  parameter int                  TIMEOUT_CYCLES = 255,
  parameter int                  CNT_W          = 8,
  parameter logic [WB_DAT_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_val,
  output logic                cmd_rdy,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  output logic                rsp_val,
  input  logic                rsp_rdy,
  output logic                rsp_we,
  output logic                rsp_err,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  output logic                busy,
  output logic [15:0]         txn_cnt,
  output logic [7:0]          err_cnt
);

  state_t state, state_nxt;

  logic accept;
  logic done_ack;
  logic done_to;
  logic rsp_pop;
  logic ctr_clr;
  logic ctr_en;
  logic expired;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_val)                state_nxt = ST_BUS;
      ST_BUS:  if (wbm_ack_i || expired)   state_nxt = ST_RSP;
      ST_RSP:  if (rsp_rdy)                state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  // Ack has priority over the timeout in the same cycle.
  always_comb begin
    cmd_rdy  = (state == ST_IDLE);
    busy     = (state != ST_IDLE);
    accept   = (state == ST_IDLE) && cmd_val;
    done_ack = (state == ST_BUS) && wbm_ack_i;
    done_to  = (state == ST_BUS) && !wbm_ack_i && expired;
    rsp_pop  = (state == ST_RSP) && rsp_rdy;
    ctr_clr  = accept;
    ctr_en   = (state == ST_BUS) && !wbm_ack_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_val   <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
      txn_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      if (accept) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= cmd_we;
        wbm_sel_o <= cmd_sel;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_we ? cmd_dat : '0;
      end

      if (done_ack || done_to) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        rsp_val   <= 1'b1;
        rsp_we    <= wbm_we_o;
        rsp_err   <= done_to;
        if (wbm_we_o)     rsp_dat <= '0;
        else if (done_to) rsp_dat <= ERR_DATA;
        else              rsp_dat <= wbm_dat_i;
        txn_cnt <= txn_cnt + 16'd1;
        if (done_to && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end

      if (rsp_pop) rsp_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_master.sv
module tb_wb_master;

  localparam int T = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_val = 1'b0;
  logic        cmd_rdy;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_dat = '0;
  logic        rsp_val;
  logic        rsp_rdy = 1'b0;
  logic        rsp_we;
  logic        rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;
  logic        busy;
  logic [15:0] txn_cnt;
  logic [7:0]  err_cnt;

  wb_master #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_we(rsp_we),
    .rsp_err(rsp_err), .rsp_dat(rsp_dat),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
    .busy(busy), .txn_cnt(txn_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int m_txn  = 0;
  int m_err  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: ack arrives after 'waits' wait states unless that is past
  // the timeout window; ack in the last window cycle still counts as ack.
  function automatic void ref_rsp(input logic we, input int waits, input logic [31:0] rdata,
                                  output int cyc, output logic err, output logic [31:0] dat);
    err = (waits >= T);
    cyc = err ? T : waits + 1;
    dat = we ? 32'h0 : (err ? 32'hDEAD_BEEF : rdata);
  endfunction

  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input int waits, input logic [31:0] rdata,
                        input int hold, input bit bp_cmd,
                        input int exp_cyc, input logic exp_err, input logic [31:0] exp_dat);
    int k;
    chk("cmd_rdy_idle", cmd_rdy, 1);
    cmd_val = 1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
    tick();
    cmd_val = 0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom;
    k = 0;
    while (wbm_cyc_o === 1'b1 && k < 200) begin
      if (k == 0) begin
        chk("stb", wbm_stb_o, 1);
        chk("wbm_we", wbm_we_o, we);
        chk("wbm_adr", wbm_adr_o, adr);
        chk("wbm_sel", wbm_sel_o, sel);
        chk("wbm_dat", wbm_dat_o, we ? dat : 32'h0);
        chk("busy_bus", busy, 1);
        chk("cmd_rdy_bus", cmd_rdy, 0);
      end
      wbm_ack_i = (k == waits);
      wbm_dat_i = (k == waits) ? rdata : $urandom;
      tick();
      wbm_ack_i = 0;
      wbm_dat_i = $urandom;
      k++;
    end
    chk("cyc_len", k, exp_cyc);
    m_txn++;
    if (exp_err && m_err < 255) m_err++;
    chk("rsp_val", rsp_val, 1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("rsp_we", rsp_we, we);
    chk("txn_cnt", txn_cnt, m_txn[15:0]);
    chk("err_cnt", err_cnt, m_err);
    if (bp_cmd) begin
      cmd_val = 1; cmd_we = 0; cmd_adr = 32'h4000_0010; cmd_sel = 4'hF;
    end
    for (int h = 0; h < hold; h++) begin
      wbm_ack_i = 1'($urandom_range(0, 1));
      wbm_dat_i = $urandom;
      tick();
      chk("hold_val", rsp_val, 1);
      chk("hold_dat", rsp_dat, exp_dat);
      chk("hold_err", rsp_err, exp_err);
      chk("hold_rdy", cmd_rdy, 0);
      chk("hold_cyc", wbm_cyc_o, 0);
      chk("hold_txn", txn_cnt, m_txn[15:0]);
    end
    wbm_ack_i = 0;
    rsp_rdy = 1;
    tick();
    rsp_rdy = 0;
    chk("pop_val", rsp_val, 0);
    chk("pop_rdy", cmd_rdy, 1);
    chk("pop_cyc", wbm_cyc_o, 0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          waits;
    logic [31:0] rdata;
    int          hold;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   e_cyc;
    logic e_err;
    logic [31:0] e_dat;

    vecs[0] = '{1'b1, 32'h3000_0004, 4'hF, 32'hA5A5_1234, 0,     32'h0,         0, 1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h3000_0008, 4'hF, 32'h0,        3,     32'hCAFE_F00D, 1, 4, 1'b0, 32'hCAFE_F00D};
    vecs[2] = '{1'b0, 32'h3000_000C, 4'hF, 32'h0,        NEVER, 32'h0,         2, 8, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h3000_0010, 4'h3, 32'h0,        7,     32'h1234_5678, 0, 8, 1'b0, 32'h1234_5678};
    vecs[4] = '{1'b1, 32'h3000_0014, 4'hC, 32'h5555_AAAA, NEVER, 32'h0,        1, 8, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h3000_0018, 4'h1, 32'h0,        6,     32'h0BAD_F00D, 3, 7, 1'b0, 32'h0BAD_F00D};

    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_rsp_val", rsp_val, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_txn", txn_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_rdy", cmd_rdy, 1);

    for (int i = 0; i < 6; i++)
      do_txn(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].waits,
             vecs[i].rdata, vecs[i].hold, 1'b0, vecs[i].exp_cyc, vecs[i].exp_err, vecs[i].exp_dat);

    // Stray acks while idle.
    for (int i = 0; i < 3; i++) begin
      wbm_ack_i = 1; wbm_dat_i = $urandom;
      tick();
    end
    wbm_ack_i = 0;
    chk("stray_busy", busy, 0);
    chk("stray_cyc", wbm_cyc_o, 0);
    chk("stray_rsp", rsp_val, 0);
    chk("stray_txn", txn_cnt, m_txn[15:0]);

    // Backpressure with a command already waiting.
    do_txn(1'b1, 32'h3000_0020, 4'hF, 32'h0000_BEEF, 1, 32'h0, 5, 1'b1, 2, 1'b0, 32'h0);
    tick();
    chk("bp_accept_cyc", wbm_cyc_o, 1);
    chk("bp_accept_adr", wbm_adr_o, 32'h4000_0010);
    cmd_val = 0;
    wbm_ack_i = 1; wbm_dat_i = 32'h1111_2222;
    tick();
    wbm_ack_i = 0;
    m_txn++;
    chk("bp_rsp_val", rsp_val, 1);
    chk("bp_rsp_dat", rsp_dat, 32'h1111_2222);
    chk("bp_txn", txn_cnt, m_txn[15:0]);
    rsp_rdy = 1;
    tick();
    rsp_rdy = 0;

    // Randomized traffic against the reference.
    for (int i = 0; i < 40; i++) begin
      logic        we;
      int          waits;
      logic [31:0] rdata;
      we    = 1'($urandom_range(0, 1));
      waits = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 9));
      rdata = $urandom;
      ref_rsp(we, waits, rdata, e_cyc, e_err, e_dat);
      do_txn(we, $urandom, 4'($urandom), $urandom, waits, rdata,
             int'($urandom_range(0, 3)), 1'b0, e_cyc, e_err, e_dat);
    end

    // Reset during a wait state.
    cmd_val = 1; cmd_we = 0; cmd_adr = 32'h3000_0100; cmd_sel = 4'hF;
    tick();
    cmd_val = 0;
    tick(); tick();
    chk("mid_cyc_before", wbm_cyc_o, 1);
    rst = 1;
    tick();
    chk("mid_rst_cyc", wbm_cyc_o, 0);
    chk("mid_rst_stb", wbm_stb_o, 0);
    chk("mid_rst_val", rsp_val, 0);
    chk("mid_rst_txn", txn_cnt, 0);
    chk("mid_rst_err", err_cnt, 0);
    rst = 0;
    tick();
    chk("mid_rst_no_rsp", rsp_val, 0);
    chk("mid_rst_busy", busy, 0);
    m_txn = 0;
    m_err = 0;

    // Error counter saturation.
    for (int i = 0; i < 300; i++)
      do_txn(1'b0, 32'h3000_0200, 4'hF, 32'h0, NEVER, 32'h0, 0, 1'b0, T, 1'b1, 32'hDEAD_BEEF);
    chk("sat_err_cnt", err_cnt, 8'd255);
    chk("sat_txn_cnt", txn_cnt, 16'd300);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
